// File: rtl/bist_march_engine.sv
// bist_march_engine: March C- memory test datapath run under the BIST controller.
// Issues one memory operation per cycle and tracks sticky pass/fail status.
module bist_march_engine #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  running,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            error_count
);
  typedef enum logic [2:0] {IDLE, W0, R0W1, R1W0, R0, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  state_t st_q, st_d, nxt_elem;
  logic ph_q, ph_d, busy_q, busy_d, we_q, we_d, re_q, re_d;
  logic fail_q, fail_d, done_q, done_d, last, issue, mism;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, fail_addr_q, fail_addr_d, step;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, expect_v;
  logic [7:0] err_q, err_d;
  // st/ph/addr point at the operation presented this cycle when busy_q,
  // or at the operation still pending while paused.
  always_comb begin
    last = (st_q == R1W0) ? (addr_q == '0) : (addr_q == LAST);
    step = (st_q == R1W0) ? addr_q - 1'b1 : addr_q + 1'b1;
    nxt_elem = (st_q == W0) ? R0W1 : (st_q == R0W1) ? R1W0 : (st_q == R1W0) ? R0 : DONE;
    st_d = st_q;
    ph_d = ph_q;
    addr_d = addr_q;
    if (st_q == IDLE) st_d = running ? W0 : IDLE;
    else if (busy_q && st_q != W0 && !ph_q) ph_d = 1'b1;
    else if (busy_q && last) begin
      st_d = nxt_elem;
      ph_d = 1'b0;
      addr_d = (nxt_elem == R1W0) ? LAST : '0;
    end else if (busy_q) begin
      ph_d = 1'b0;
      addr_d = step;
    end
    // A phase B is always issued so a read in flight is never dropped.
    issue = st_d != IDLE && st_d != DONE && (ph_d || running);
    expect_v = (st_q == R1W0) ? ONES : '0;
    mism = busy_q && ph_q && mem_rdata != expect_v;
    err_d = (mism && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    fail_d = fail_q | mism;
    fail_addr_d = (mism && !fail_q) ? addr_q : fail_addr_q;
    busy_d = issue;
    we_d = issue && (st_d == W0 || (ph_d && st_d != R0));
    re_d = issue && st_d != W0 && !ph_d;
    wdata_d = (st_d == R0W1) ? ONES : '0;
    done_d = st_d == DONE;
    if (init) begin
      st_d = IDLE;
      ph_d = 1'b0;
      addr_d = '0;
      busy_d = 1'b0;
      we_d = 1'b0;
      re_d = 1'b0;
      wdata_d = '0;
      err_d = '0;
      fail_d = 1'b0;
      fail_addr_d = '0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;
      ph_q <= 1'b0;
      addr_q <= '0;
      busy_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      wdata_q <= '0;
      err_q <= '0;
      fail_q <= 1'b0;
      fail_addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      ph_q <= ph_d;
      addr_q <= addr_d;
      busy_q <= busy_d;
      we_q <= we_d;
      re_q <= re_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      fail_q <= fail_d;
      fail_addr_q <= fail_addr_d;
      done_q <= done_d;
    end
  end
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we = we_q;
  assign mem_re = re_q;
  assign done = done_q;
  assign fail = fail_q;
  assign fail_addr = fail_addr_q;
  assign error_count = err_q;
endmodule

// File: tb/tb_bist_march_engine.sv
// tb_bist_march_engine: scoreboarded bench for bist_march_engine against a 16x8 RAM
// model with selectable read faults.
module tb_bist_march_engine;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic init = 1'b0;
  logic running = 1'b0;
  logic [3:0] mem_addr, fail_addr;
  logic [7:0] mem_wdata, mem_rdata, error_count;
  logic mem_we, mem_re, done, fail;
  int total = 0;
  int bad = 0;
  int fault_mode = 0;
  logic [7:0] ram [0:15];
  typedef struct packed {logic we; logic re; logic [3:0] addr; logic [7:0] wdata;} op_t;
  op_t sb[$];
  op_t got_op, exp_op;

  bist_march_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .init(init), .running(running),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .done(done), .fail(fail), .fail_addr(fail_addr),
    .error_count(error_count)
  );

  always #5 clock = ~clock;

  // fault_mode 1: bit 3 of word 5 reads as 0; fault_mode 2: every read returns 0x55
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (fault_mode == 2) ? 8'h55 :
                             (fault_mode == 1 && mem_addr == 4'd5) ? (ram[mem_addr] & 8'hF7) : ram[mem_addr];
  end

  always @(negedge clock) begin
    if (!reset && (mem_we || mem_re)) begin
      total++;
      got_op = {mem_we, mem_re, mem_addr, mem_we ? mem_wdata : 8'h00};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got=%h want=none", got_op);
      end else begin
        exp_op = sb.pop_front();
        if (got_op !== exp_op) begin
          bad++;
          $display("FAIL sb_op got=%h want=%h", got_op, exp_op);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_march();
    sb.delete();
    for (int a = 0; a < 16; a++) sb.push_back({1'b1, 1'b0, 4'(a), 8'h00});
    for (int a = 0; a < 16; a++) begin
      sb.push_back({1'b0, 1'b1, 4'(a), 8'h00});
      sb.push_back({1'b1, 1'b0, 4'(a), 8'hFF});
    end
    for (int a = 15; a >= 0; a--) begin
      sb.push_back({1'b0, 1'b1, 4'(a), 8'h00});
      sb.push_back({1'b1, 1'b0, 4'(a), 8'h00});
    end
    for (int a = 0; a < 16; a++) sb.push_back({1'b0, 1'b1, 4'(a), 8'h00});
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
  endtask

  task automatic wait_edges(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_to_done(input int max, output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!done && n < max);
  endtask

  task automatic do_init();
    @(negedge clock);
    running = 1'b0;
    init = 1'b1;
    @(negedge clock);
    init = 1'b0;
  endtask

  task automatic test_reset();
    #50;
    total++;
    if ({done, fail, fail_addr, error_count, mem_we, mem_re, mem_addr, mem_wdata} !== 28'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {done, fail, fail_addr, error_count, mem_we, mem_re, mem_addr, mem_wdata});
    end
    #50;
    reset = 1'b0;
    wait_edges(3);
    total++;
    if ({done, mem_we, mem_re, mem_addr} !== 7'h0) begin
      bad++;
      $display("FAIL idle_hold got=%h want=0", {done, mem_we, mem_re, mem_addr});
    end
  endtask

  task automatic test_clean();
    int n;
    logic ok;
    fault_mode = 0;
    fill_ram();
    push_march();
    @(negedge clock);
    running = 1'b1;
    run_to_done(300, n);
    total++;
    if (n !== 113) begin bad++; $display("FAIL clean_len got=%0d want=113", n); end
    total++;
    if ({fail, error_count, fail_addr} !== 13'h0) begin
      bad++;
      $display("FAIL clean_status got=%h want=0", {fail, error_count, fail_addr});
    end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL clean_sb_left got=%0d want=0", sb.size()); end
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (ram[i] !== 8'h00) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL clean_ram got=nonzero want=all_zero"); end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_edges(1);
      if (!done || mem_we || mem_re) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL done_hold got=restart want=hold"); end
    do_init();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL init_clear_done got=%b want=0", done); end
  endtask

  task automatic test_stuck();
    int n;
    fault_mode = 1;
    fill_ram();
    push_march();
    @(negedge clock);
    running = 1'b1;
    wait_edges(70);
    total++;
    if (fail !== 1'b0) begin bad++; $display("FAIL stuck_early got=%b want=0", fail); end
    wait_edges(1);
    total++;
    if ({fail, fail_addr} !== {1'b1, 4'd5}) begin
      bad++;
      $display("FAIL stuck_first got=%h want=15", {fail, fail_addr});
    end
    run_to_done(100, n);
    total++;
    if (71 + n !== 113) begin bad++; $display("FAIL stuck_len got=%0d want=113", 71 + n); end
    total++;
    if ({done, fail, fail_addr, error_count} !== {1'b1, 1'b1, 4'd5, 8'd1}) begin
      bad++;
      $display("FAIL stuck_final got=%h want=%h", {done, fail, fail_addr, error_count}, {1'b1, 1'b1, 4'd5, 8'd1});
    end
    do_init();
  endtask

  task automatic test_pause();
    int n;
    logic ok;
    fault_mode = 0;
    fill_ram();
    push_march();
    @(negedge clock);
    running = 1'b1;
    wait_edges(32);
    total++;
    if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'd7, 8'hFF}) begin
      bad++;
      $display("FAIL pause_phase_b got=%h want=%h", {mem_we, mem_re, mem_addr, mem_wdata}, {1'b1, 1'b0, 4'd7, 8'hFF});
    end
    running = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_edges(1);
      if (mem_we || mem_re) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL pause_quiet got=strobe want=none"); end
    running = 1'b1;
    run_to_done(200, n);
    total++;
    if (42 + n !== 123) begin bad++; $display("FAIL pause_len got=%0d want=123", 42 + n); end
    total++;
    if ({fail, sb.size() == 0} !== 2'b01) begin
      bad++;
      $display("FAIL pause_end got=%b want=01", {fail, sb.size() == 0});
    end
    do_init();
  endtask

  task automatic test_init_mid();
    int n;
    fault_mode = 2;
    push_march();
    @(negedge clock);
    running = 1'b1;
    wait_edges(60);
    total++;
    if ({fail, fail_addr, error_count} !== {1'b1, 4'd0, 8'd21}) begin
      bad++;
      $display("FAIL mid_status got=%h want=%h", {fail, fail_addr, error_count}, {1'b1, 4'd0, 8'd21});
    end
    init = 1'b1;
    wait_edges(1);
    init = 1'b0;
    fault_mode = 0;
    push_march();
    total++;
    if ({done, fail, fail_addr, error_count, mem_we, mem_re, mem_addr, mem_wdata} !== 28'h0) begin
      bad++;
      $display("FAIL mid_init got=%h want=0", {done, fail, fail_addr, error_count, mem_we, mem_re, mem_addr, mem_wdata});
    end
    wait_edges(1);
    total++;
    if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'd0, 8'h00}) begin
      bad++;
      $display("FAIL mid_restart got=%h want=%h", {mem_we, mem_re, mem_addr, mem_wdata}, {1'b1, 1'b0, 4'd0, 8'h00});
    end
    run_to_done(200, n);
    total++;
    if ({n + 1 == 113, fail, error_count} !== {1'b1, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL mid_rerun got=len%0d fail%b err%0d want=len113 fail0 err0", n + 1, fail, error_count);
    end
    do_init();
  endtask

  task automatic test_async_reset();
    fault_mode = 0;
    push_march();
    @(negedge clock);
    running = 1'b1;
    wait_edges(90);
    #2;
    reset = 1'b1;
    running = 1'b0;
    #1;
    total++;
    if ({done, fail, fail_addr, error_count, mem_we, mem_re, mem_addr, mem_wdata} !== 28'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {done, fail, fail_addr, error_count, mem_we, mem_re, mem_addr, mem_wdata});
    end
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    wait_edges(2);
    total++;
    if ({done, mem_we, mem_re} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=000", {done, mem_we, mem_re});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    fault_mode = 2;
    push_march();
    @(negedge clock);
    running = 1'b1;
    run_to_done(300, n);
    total++;
    if ({n == 113, fail, fail_addr, error_count} !== {1'b1, 1'b1, 4'd0, 8'd48}) begin
      bad++;
      $display("FAIL sat_run1 got=len%0d fail%b addr%0d err%0d want=len113 fail1 addr0 err48", n, fail, fail_addr, error_count);
    end
    do_init();
    total++;
    if (error_count !== 8'd0) begin bad++; $display("FAIL sat_init got=%0d want=0", error_count); end
    push_march();
    running = 1'b1;
    wait_edges(3);
    @(negedge clock);
    force dut.err_q = 8'd250;
    wait_edges(1);
    release dut.err_q;
    total++;
    if (error_count !== 8'd250) begin bad++; $display("FAIL sat_preload got=%0d want=250", error_count); end
    run_to_done(300, n);
    total++;
    if ({4 + n == 113, done, error_count} !== {1'b1, 1'b1, 8'd255}) begin
      bad++;
      $display("FAIL sat_final got=len%0d done%b err%0d want=len113 done1 err255", 4 + n, done, error_count);
    end
    wait_edges(3);
    total++;
    if (error_count !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", error_count); end
    do_init();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck();
    test_pause();
    test_init_mid();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bist_march_engine.md
Name: bist_march_engine

Overview:
- Downstream datapath stage of the BIST state_machine: runs a March C- style memory test while the controller signals running.
- Reports completion back via done, which the controller consumes as bist_end.
- Drives a single-port synchronous test memory: address, write data, write/read strobes, 1-cycle read latency.
- Produces sticky pass/fail status, first failing address and a saturating error count.

Parameters:
- ADDR_WIDTH, 4, memory address width; N = 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, memory word width; pattern "0" = all zeros, pattern "1" = all ones.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  synchronous clear pulse from state_machine: return to IDLE, clear all status.
- running  in  1  level enable from state_machine: test advances only while high.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_we  out  1  write strobe, one word per cycle.
- mem_re  out  1  read strobe; data valid on mem_rdata the following cycle.
- mem_rdata  in  DATA_WIDTH  read data.
- done  out  1  test complete (feeds bist_end); held until init/reset.
- fail  out  1  sticky: any compare mismatch.
- fail_addr  out  ADDR_WIDTH  address of first mismatch.
- error_count  out  8  mismatch count, saturates at 255.

Behaviour:
- Reset and init: state IDLE; all outputs 0 (done, fail, fail_addr, error_count, mem_* strobes, mem_addr, mem_wdata). Async reset wins over everything. init is synchronous and has priority over running.
- States: IDLE, W0, R0W1, R1W0, R0, DONE.
- IDLE -> W0 when running=1. Address counter starts at 0 (ascending elements) or N-1 (descending).
- W0 (ascending): 1 cycle per address, mem_we=1, wdata=0. After addr N-1, go to R0W1 at addr 0.
- Read elements use 2 cycles per address:
  - Phase A: mem_re=1.
  - Phase B: compare mem_rdata with the expected value; for R0W1/R1W0 also mem_we=1 with the new pattern at the same address.
- R0W1: ascending, expect 0, write 1. After addr N-1, go to R1W0 at addr N-1.
- R1W0: descending, expect 1, write 0. After addr 0, go to R0 at addr 0.
- R0: ascending, expect 0, no write. After phase B of addr N-1, go to DONE.
- DONE: done=1, no strobes, hold until init or reset. running=1 in DONE does not restart.
- Mismatch in phase B:
  - error_count increments, saturating at 255.
  - On the first mismatch (fail==0), fail_addr takes the current address.
  - fail is set at the next edge.
- Pause: running=0 during phase A, or before a W0 write, holds state with no strobes asserted. A phase B already entered always completes, so a pending read is never dropped. Resumes on the same address and phase.
- Total run length with running held high: 7N cycles from the first W0 write to entering DONE. For N=16: 112 cycles, done high on the 113th edge after leaving IDLE.
- mem_addr and mem_wdata are registered and change only with state/phase. Outputs are don't-care when no strobe is asserted, but are driven to 0 in IDLE and DONE.
- Address counter wraps only at element boundaries; no out-of-range addresses are ever issued.

Test Plan:
- Clean run with a 16x8 behavioural RAM model: reset 1 for 100 ns, then running=1 -> W0 writes addr 0..15 with 0x00; done=1 after 112 active cycles; fail=0, error_count=0; final RAM all 0x00.
- Stuck-at-0 at bit 3 of addr 5 -> first mismatch in R1W0 (expect 0xFF, read 0xF7); fail=1, fail_addr=5, error_count=1, done still asserted at the end.
- Pause: drop running for 10 cycles after phase A of R0W1 addr 7 -> phase B completes (write 0xFF to 7), then no strobes for the pause, resume at addr 8 phase A; total active cycles still 112.
- Mid-test init: pulse init during R1W0 -> next cycle state IDLE, done/fail/error_count=0, strobes low; with running high the test restarts from W0 addr 0.
- Async reset asserted between edges during R0 -> all outputs 0 immediately, before the next clock edge.
- Saturation: RAM forced to return 0x55 on every read -> error_count reaches 255 and holds (48 compares per run; back-to-back runs via init without reset, or a forced-count override); fail_addr=0 from the first R0W1 compare.
